ipv4_pkt_gen: RTL and testbench
===============================

Name: ipv4_pkt_gen

Overview:
Hardware IPv4 traffic generator: the transmit-side counterpart of the basic_router ingress stream. It builds single-beat Ethernet/IPv4 frames from latched configuration and drives them onto a 512-bit AXI-Stream master. It sits in front of the router's s_axis input, for on-chip stimulus and loopback bring-up.

Parameters:
DATA_WIDTH, 512, AXI-Stream data width in bits; fixed at 512, other values unsupported.
CNT_WIDTH, 32, width of the packet-count, sequence and sent-count counters.

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
start  in  1  1-cycle pulse; latches cfg_* and begins a run (ignored while busy)
stop  in  1  request to end the run after the current beat
cfg_dst_mac  in  48  Ethernet destination MAC
cfg_src_mac  in  48  Ethernet source MAC
cfg_src_ip  in  32  IPv4 source address
cfg_dst_ip_base  in  32  first destination IP
cfg_dst_ip_count  in  16  number of consecutive destination IPs to cycle; 0 treated as 1
cfg_ttl  in  8  TTL field
cfg_protocol  in  8  protocol field
cfg_pkt_count  in  CNT_WIDTH  packets per run; 0 = continuous until stop
cfg_gap  in  16  idle cycles between packets
m_axis_tdata  out  DATA_WIDTH  frame beat
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  downstream ready
m_axis_tkeep  out  DATA_WIDTH/8  byte enables
m_axis_tlast  out  1  end of frame
busy  out  1  high in any state other than IDLE
done  out  1  1-cycle pulse when a run ends (count reached or stop)
sent_count  out  CNT_WIDTH  accepted beats in the current/last run

Behaviour:
- Reset: state=IDLE; tvalid, tlast, busy and done = 0; tdata and tkeep = 0; sent_count, sequence = 0.
- FSM states: IDLE, BUILD, SEND, GAP.
- IDLE: on start && !stop, latch all cfg_*, clear sent_count and seq, go to BUILD. If start and stop are high together, stop wins and nothing happens.
- BUILD: register tdata for the current seq. Takes 1 cycle, or 2 with IPV4_CSUM_EN. Then go to SEND.
- Frame layout (bits not listed are 0):
  - [47:0] dst_mac; [95:48] src_mac; [111:96] 16'h0800.
  - [115:112] 4; [119:116] 5; [127:120] 0; [143:128] 20.
  - [159:144] seq[15:0]; [162:160] 3'b010; [175:163] 0.
  - [183:176] ttl; [191:184] protocol; [207:192] checksum.
  - [239:208] src_ip; [271:240] dst_ip.
- dst_ip = base + (seq mod count), 32-bit wrapping add.
- SEND outputs: tvalid=1, tlast=1, tkeep=64'h0000_0003_FFFF_FFFF (34 bytes).
- SEND hold rule: tdata, tkeep, tlast stay stable and tvalid never drops until tvalid && tready. tvalid is low in every other state.
- On handshake: sent_count++ and seq++ (both wrap at 2^CNT_WIDTH). Next state:
  - pkt_count!=0 and new sent_count==pkt_count, or stop seen since the last handshake: IDLE, pulse done.
  - else cfg_gap==0: BUILD.
  - else: GAP, loading a down-counter with cfg_gap.
- stop is sticky within a run: cleared on start, set on stop in any non-IDLE state.
- GAP: decrement each cycle; at 1, go to BUILD. If stop is seen in GAP or BUILD, go to IDLE with a done pulse; no further beat is emitted.
- Throughput: with gap 0 and tready=1, one beat every 2 cycles (3 with IPV4_CSUM_EN).
- Mid-run reset: immediate return to reset values; a beat may be truncated, which is acceptable.
- cfg_* changes after start have no effect until the next start.

Optional Feature:
IPV4_CSUM_EN.
- Defined: BUILD computes the IPv4 header checksum over the ten 16-bit slices tdata[112+16k+15 : 112+16k], k=0..9. The checksum slice is taken as 0; the sum uses end-around carry; the ones' complement of the result is written to [207:192]. Adds one BUILD pipeline cycle.
- Undefined: [207:192]=16'h0000 and BUILD is 1 cycle.

Test Plan:
- Basic run: cfg_pkt_count=3, dst_ip_base=C0A80164, count=1, gap=0, tready=1. Expect 3 beats, each with dst_ip=C0A80164 and ID 0,1,2; tkeep=0x3_FFFF_FFFF; done pulse once; sent_count=3; busy drops.
- IP cycling: base=0A000000, count=4, pkt_count=6. Expect dst_ip sequence .00,.01,.02,.03,.00,.01.
- Backpressure: tready low for 10 cycles during SEND. tvalid stays high and tdata stays unchanged throughout; exactly one beat is accepted when tready rises.
- Stop handling: pkt_count=0, gap=5; assert stop mid-GAP after 2 beats. Expect no third beat, done pulse, sent_count=2. Also start+stop together in IDLE: no activity.
- Gap timing: gap=3, tready=1. Expect handshakes exactly 2+3=5 cycles apart (6 with IPV4_CSUM_EN).
- Checksum (IPV4_CSUM_EN): src=C0A80101, dst=C0A80164, ttl=64, proto=0x11, seq=0. The [207:192] field must equal the bench-computed ones'-complement sum; a re-sum including the checksum field yields 16'hFFFF.

Source files
------------

// File: rtl/ipv4_pkt_gen_if.sv
// AXI-Stream beat bundle for the IPv4 traffic generator.
// Master drives the frame beat, slave returns tready.
interface ipv4_pkt_gen_if #(
   parameter int DATA_WIDTH = 512
) ();
   logic [DATA_WIDTH-1:0]   tdata;
   logic                    tvalid;
   logic                    tready;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic                    tlast;

   modport master (
      output tdata, tvalid, tkeep, tlast,
      input  tready
   );

   modport slave (
      input  tdata, tvalid, tkeep, tlast,
      output tready
   );
endinterface

// File: rtl/ipv4_pkt_gen.sv
// Single-beat Ethernet/IPv4 frame generator on an AXI-Stream master.
// Define IPV4_CSUM_EN to fill the header checksum (adds a BUILD cycle).
module ipv4_pkt_gen #(
   parameter int DATA_WIDTH = 512,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic                 start,
   input  logic                 stop,
   input  logic [47:0]          cfg_dst_mac,
   input  logic [47:0]          cfg_src_mac,
   input  logic [31:0]          cfg_src_ip,
   input  logic [31:0]          cfg_dst_ip_base,
   input  logic [15:0]          cfg_dst_ip_count,
   input  logic [7:0]           cfg_ttl,
   input  logic [7:0]           cfg_protocol,
   input  logic [CNT_WIDTH-1:0] cfg_pkt_count,
   input  logic [15:0]          cfg_gap,
   ipv4_pkt_gen_if.master       m_axis,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] sent_count
);

   typedef enum logic [1:0] {IDLE, BUILD, SEND, GAP} state_t;

   localparam logic [DATA_WIDTH/8-1:0] KEEP =
      {{(DATA_WIDTH/8-34){1'b0}}, {34{1'b1}}};

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic [CNT_WIDTH-1:0]  seq_q, seq_d;
   logic [CNT_WIDTH-1:0]  sent_q, sent_d;
   logic [15:0]           gcnt_q, gcnt_d;
   logic                  stop_q, stop_d;
   logic                  done_q, done_d;

   logic [47:0]           dmac_q, smac_q;
   logic [31:0]           sip_q, base_q;
   logic [15:0]           ipcnt_q, gap_q;
   logic [7:0]            ttl_q, proto_q;
   logic [CNT_WIDTH-1:0]  pkt_q;

   logic                  launch, halt;
   logic [15:0]           ipcnt_eff;
   logic [CNT_WIDTH-1:0]  ip_idx;
   logic [31:0]           dst_ip;
   logic [DATA_WIDTH-1:0] frame;

   assign launch    = (state_q == IDLE) && start && !stop;
   assign halt      = stop_q || stop;
   assign ipcnt_eff = (ipcnt_q == 16'd0) ? 16'd1 : ipcnt_q;
   assign ip_idx    = seq_q % {{(CNT_WIDTH-16){1'b0}}, ipcnt_eff};
   assign dst_ip    = base_q + ip_idx[31:0];

`ifdef IPV4_CSUM_EN
   logic        bld_q, bld_d;
   logic [19:0] sum;
   logic [15:0] csum;

   // ones' complement sum of the header words already sitting in tdata_q
   always_comb begin
      sum = '0;
      for (int k = 0; k < 10; k++)
         if (k != 5) sum = sum + {4'h0, tdata_q[112+16*k +: 16]};
      sum  = {4'h0, sum[15:0]} + {16'h0, sum[19:16]};
      sum  = {4'h0, sum[15:0]} + {16'h0, sum[19:16]};
      csum = ~sum[15:0];
   end
`endif

   // frame for the current sequence number, checksum field left at zero
   always_comb begin
      frame          = '0;
      frame[47:0]    = dmac_q;
      frame[95:48]   = smac_q;
      frame[111:96]  = 16'h0800;
      frame[115:112] = 4'd4;
      frame[119:116] = 4'd5;
      frame[143:128] = 16'd20;
      frame[159:144] = seq_q[15:0];
      frame[162:160] = 3'b010;
      frame[183:176] = ttl_q;
      frame[191:184] = proto_q;
      frame[239:208] = sip_q;
      frame[271:240] = dst_ip;
   end

   // next-state and datapath updates for the run FSM
   always_comb begin
      state_d = state_q;
      tdata_d = tdata_q;
      seq_d   = seq_q;
      sent_d  = sent_q;
      gcnt_d  = gcnt_q;
      stop_d  = stop_q;
      done_d  = 1'b0;
`ifdef IPV4_CSUM_EN
      bld_d   = bld_q;
`endif
      if (state_q != IDLE && stop) stop_d = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (launch) begin
               sent_d  = '0;
               seq_d   = '0;
               stop_d  = 1'b0;
               state_d = BUILD;
            end
         end
         BUILD: begin
            if (halt) begin
               state_d = IDLE;
               done_d  = 1'b1;
`ifdef IPV4_CSUM_EN
               bld_d   = 1'b0;
`endif
            end else begin
`ifdef IPV4_CSUM_EN
               if (!bld_q) begin
                  tdata_d = frame;
                  bld_d   = 1'b1;
               end else begin
                  tdata_d[207:192] = csum;
                  bld_d   = 1'b0;
                  state_d = SEND;
               end
`else
               tdata_d = frame;
               state_d = SEND;
`endif
            end
         end
         SEND: begin
            if (m_axis.tready) begin
               sent_d = sent_q + CNT_WIDTH'(1);
               seq_d  = seq_q + CNT_WIDTH'(1);
               if ((pkt_q != '0 && sent_d == pkt_q) || halt) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else if (gap_q == 16'd0) begin
                  state_d = BUILD;
               end else begin
                  state_d = GAP;
                  gcnt_d  = gap_q;
               end
            end
         end
         GAP: begin
            if (halt) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (gcnt_q == 16'd1) begin
               state_d = BUILD;
            end else begin
               gcnt_d = gcnt_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // run state registers
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= IDLE;
         tdata_q <= '0;
         seq_q   <= '0;
         sent_q  <= '0;
         gcnt_q  <= '0;
         stop_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef IPV4_CSUM_EN
         bld_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tdata_q <= tdata_d;
         seq_q   <= seq_d;
         sent_q  <= sent_d;
         gcnt_q  <= gcnt_d;
         stop_q  <= stop_d;
         done_q  <= done_d;
`ifdef IPV4_CSUM_EN
         bld_q   <= bld_d;
`endif
      end
   end

   // configuration snapshot taken when a run is launched
   always_ff @(posedge aclk) begin
      if (areset) begin
         dmac_q  <= '0;
         smac_q  <= '0;
         sip_q   <= '0;
         base_q  <= '0;
         ipcnt_q <= '0;
         ttl_q   <= '0;
         proto_q <= '0;
         pkt_q   <= '0;
         gap_q   <= '0;
      end else if (launch) begin
         dmac_q  <= cfg_dst_mac;
         smac_q  <= cfg_src_mac;
         sip_q   <= cfg_src_ip;
         base_q  <= cfg_dst_ip_base;
         ipcnt_q <= cfg_dst_ip_count;
         ttl_q   <= cfg_ttl;
         proto_q <= cfg_protocol;
         pkt_q   <= cfg_pkt_count;
         gap_q   <= cfg_gap;
      end
   end

   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = (state_q == SEND);
   assign m_axis.tlast  = (state_q == SEND);
   assign m_axis.tkeep  = (state_q == SEND) ? KEEP : '0;
   assign busy          = (state_q != IDLE);
   assign done          = done_q;
   assign sent_count    = sent_q;

endmodule

// File: tb/tb_ipv4_pkt_gen.sv
// Randomized self-checking bench for ipv4_pkt_gen.
// Frames are predicted field by field from the header layout.
module tb_ipv4_pkt_gen;

   localparam logic [63:0] KEEP = 64'h0000_0003_FFFF_FFFF;
`ifdef IPV4_CSUM_EN
   localparam int BLD = 2;
`else
   localparam int BLD = 1;
`endif

   logic        aclk = 1'b0;
   logic        areset, start, stop;
   logic [47:0] cfg_dst_mac, cfg_src_mac;
   logic [31:0] cfg_src_ip, cfg_dst_ip_base;
   logic [15:0] cfg_dst_ip_count, cfg_gap;
   logic [7:0]  cfg_ttl, cfg_protocol;
   logic [31:0] cfg_pkt_count;
   logic        busy, done;
   logic [31:0] sent_count;

   ipv4_pkt_gen_if m_axis_if ();

   ipv4_pkt_gen dut (
      .aclk             (aclk),
      .areset           (areset),
      .start            (start),
      .stop             (stop),
      .cfg_dst_mac      (cfg_dst_mac),
      .cfg_src_mac      (cfg_src_mac),
      .cfg_src_ip       (cfg_src_ip),
      .cfg_dst_ip_base  (cfg_dst_ip_base),
      .cfg_dst_ip_count (cfg_dst_ip_count),
      .cfg_ttl          (cfg_ttl),
      .cfg_protocol     (cfg_protocol),
      .cfg_pkt_count    (cfg_pkt_count),
      .cfg_gap          (cfg_gap),
      .m_axis           (m_axis_if.master),
      .busy             (busy),
      .done             (done),
      .sent_count       (sent_count)
   );

   always #5 aclk = ~aclk;

   int unsigned n_asrt = 0;
   int unsigned n_fail = 0;
   int unsigned cyc    = 0;
   int unsigned ndone  = 0;
   logic [511:0] beats[$];
   int unsigned  bcyc[$];

   logic [47:0] e_dmac, e_smac;
   logic [31:0] e_sip, e_base;
   logic [15:0] e_cnt;
   logic [7:0]  e_ttl, e_proto;

   task automatic chk(input string tag, input logic [511:0] got,
                      input logic [511:0] exp);
      n_asrt++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ones_sum(input logic [511:0] f);
      int unsigned s = 0;
      for (int k = 0; k < 10; k++) s += 32'(f[112+16*k +: 16]);
      while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
      return s[15:0];
   endfunction

   function automatic logic [511:0] exp_frame(input int unsigned seq);
      logic [511:0] f = '0;
      int unsigned  n = (e_cnt == 0) ? 1 : 32'(e_cnt);
      logic [31:0]  dip = e_base + (seq % n);
      f[47:0]    = e_dmac;
      f[95:48]   = e_smac;
      f[111:96]  = 16'h0800;
      f[115:112] = 4'd4;
      f[119:116] = 4'd5;
      f[143:128] = 16'd20;
      f[159:144] = seq[15:0];
      f[162:160] = 3'b010;
      f[183:176] = e_ttl;
      f[191:184] = e_proto;
      f[239:208] = e_sip;
      f[271:240] = dip;
`ifdef IPV4_CSUM_EN
      f[207:192] = ~ones_sum(f);
`endif
      return f;
   endfunction

   always @(posedge aclk) cyc <= cyc + 1;

   // handshake and done monitor, sampled mid-cycle
   always @(negedge aclk) begin
      if (!areset) begin
         if (m_axis_if.tvalid && m_axis_if.tready) begin
            beats.push_back(m_axis_if.tdata);
            bcyc.push_back(cyc);
            chk("tkeep", 512'(m_axis_if.tkeep), 512'(KEEP));
            chk("tlast", 512'(m_axis_if.tlast), 512'(1));
         end
         if (done) ndone++;
      end
   end

   task automatic set_cfg(input logic [31:0] base, input logic [15:0] cnt,
                          input logic [31:0] pkt, input logic [15:0] gap);
      e_dmac  = 48'({$urandom(), $urandom()});
      e_smac  = 48'({$urandom(), $urandom()});
      e_sip   = $urandom();
      e_ttl   = 8'($urandom());
      e_proto = 8'($urandom());
      e_base  = base;
      e_cnt   = cnt;
      cfg_dst_mac = e_dmac;  cfg_src_mac = e_smac;
      cfg_src_ip = e_sip;    cfg_ttl = e_ttl;
      cfg_protocol = e_proto;
      cfg_dst_ip_base = base;  cfg_dst_ip_count = cnt;
      cfg_pkt_count = pkt;     cfg_gap = gap;
   endtask

   task automatic launch();
      beats.delete(); bcyc.delete(); ndone = 0;
      @(posedge aclk); #1 start = 1'b1;
      @(posedge aclk); #1 start = 1'b0;
      cfg_dst_mac = 48'({$urandom(), $urandom()});
      cfg_src_ip = $urandom(); cfg_dst_ip_base = $urandom();
      cfg_dst_ip_count = 16'($urandom()); cfg_ttl = 8'($urandom());
      cfg_pkt_count = $urandom_range(1, 9); cfg_gap = 16'($urandom());
   endtask

   task automatic wait_done(input string nm, input int rdy_pct);
      for (int i = 0; i < 3000; i++) begin
         m_axis_if.tready = ($urandom_range(99) < rdy_pct);
         @(negedge aclk); #1;
         if (ndone != 0) break;
         @(posedge aclk); #1;
      end
      m_axis_if.tready = 1'b1;
      chk({nm, "_done"}, 512'(ndone), 512'(1));
      chk({nm, "_busy"}, 512'(busy), 512'(0));
      @(posedge aclk); #1;
   endtask

   task automatic do_run(input string nm, input int unsigned npkt,
                         input int rdy_pct, input int spacing);
      launch();
      wait_done(nm, rdy_pct);
      chk({nm, "_beats"}, 512'(beats.size()), 512'(npkt));
      chk({nm, "_sent"}, 512'(sent_count), 512'(npkt));
      foreach (beats[i]) chk({nm, "_frame"}, beats[i], exp_frame(i));
      if (spacing > 0)
         for (int i = 1; i < bcyc.size(); i++)
            chk({nm, "_spacing"}, 512'(bcyc[i] - bcyc[i-1]), 512'(spacing));
   endtask

   initial begin
      logic [511:0] snap;
      logic [15:0]  fld;
      int           t;
      areset = 1'b1; start = 1'b0; stop = 1'b0;
      m_axis_if.tready = 1'b0;
      set_cfg(32'h0, 16'h0, 32'h0, 16'h0);
      repeat (3) @(posedge aclk);
      #1 areset = 1'b0;
      @(negedge aclk);
      chk("rst_tvalid", 512'(m_axis_if.tvalid), 512'(0));
      chk("rst_tlast", 512'(m_axis_if.tlast), 512'(0));
      chk("rst_tkeep", 512'(m_axis_if.tkeep), 512'(0));
      chk("rst_tdata", m_axis_if.tdata, 512'(0));
      chk("rst_busy", 512'(busy), 512'(0));
      chk("rst_done", 512'(done), 512'(0));
      chk("rst_sent", 512'(sent_count), 512'(0));

      m_axis_if.tready = 1'b1;
      set_cfg(32'hC0A80164, 16'd1, 32'd3, 16'd0);
      do_run("basic", 3, 100, BLD + 1);

      set_cfg(32'h0A000000, 16'd4, 32'd6, 16'd0);
      do_run("ipcyc", 6, 100, BLD + 1);

      set_cfg(32'hFFFFFFFE, 16'd0, 32'd3, 16'd3);
      do_run("gap3", 3, 100, BLD + 1 + 3);

      set_cfg(32'hC0A80164, 16'd1, 32'd1, 16'd0);
      e_sip = 32'hC0A80101; cfg_src_ip = e_sip;
      e_ttl = 8'd64; cfg_ttl = e_ttl;
      e_proto = 8'h11; cfg_protocol = e_proto;
      do_run("csum", 1, 100, 0);
      snap = (beats.size() > 0) ? beats[0] : '0;
      fld = snap[207:192];
`ifdef IPV4_CSUM_EN
      chk("csum_resum", 512'(ones_sum(snap)), 512'(16'hFFFF));
      snap[207:192] = 16'h0;
      chk("csum_field", 512'(fld), 512'(~ones_sum(snap)));
`else
      chk("csum_field", 512'(fld), 512'(0));
`endif

      set_cfg(32'h01020304, 16'd3, 32'd1, 16'd0);
      m_axis_if.tready = 1'b0;
      launch();
      t = 0;
      while (!m_axis_if.tvalid && t < 20) begin
         @(negedge aclk); #1; t++;
      end
      chk("bp_valid", 512'(m_axis_if.tvalid), 512'(1));
      snap = m_axis_if.tdata;
      for (int i = 0; i < 10; i++) begin
         @(negedge aclk);
         chk("bp_hold_valid", 512'(m_axis_if.tvalid), 512'(1));
         chk("bp_hold_data", m_axis_if.tdata, snap);
      end
      @(posedge aclk); #1;
      wait_done("bp", 100);
      chk("bp_beats", 512'(beats.size()), 512'(1));
      chk("bp_frame", snap, exp_frame(0));

      set_cfg(32'h0B000000, 16'd2, 32'd0, 16'd5);
      m_axis_if.tready = 1'b1;
      launch();
      t = 0;
      while (beats.size() < 2 && t < 200) begin
         @(negedge aclk); #1; t++;
      end
      @(posedge aclk); #1;
      @(posedge aclk); #1 stop = 1'b1;
      @(posedge aclk); #1 stop = 1'b0;
      wait_done("stop", 100);
      repeat (12) @(posedge aclk);
      #1;
      chk("stop_beats", 512'(beats.size()), 512'(2));
      chk("stop_sent", 512'(sent_count), 512'(2));
      chk("stop_ndone", 512'(ndone), 512'(1));

      beats.delete(); ndone = 0;
      @(posedge aclk); #1 start = 1'b1; stop = 1'b1;
      @(posedge aclk); #1 start = 1'b0; stop = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge aclk);
         chk("ss_busy", 512'(busy), 512'(0));
      end
      chk("ss_beats", 512'(beats.size()), 512'(0));
      chk("ss_done", 512'(ndone), 512'(0));

      for (int r = 0; r < 8; r++) begin
         int unsigned np = $urandom_range(1, 6);
         int          rp = $urandom_range(30, 100);
         set_cfg($urandom(), 16'($urandom_range(0, 5)), np,
                 16'($urandom_range(0, 3)));
         do_run("rand", np, rp, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end

endmodule
